alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width.
REQ-002 SHALL have parameter OP_W, default 4, ALU control-code width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 SHALL have ports reqN_ready  output  1  requester N's operation is accepted this cycle.
REQ-007 SHALL have ports reqN_a, reqN_b  input  DATA_W  operands A and B of requester N.
REQ-008 SHALL have ports reqN_op  input  OP_W  control code of requester N.
REQ-009 SHALL have port rsp_valid  output  1  response register holds a result.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-012 SHALL have port rsp_result  output  DATA_W  registered ALU result.
REQ-013 SHALL have port rsp_zero  output  1  registered zero flag, 1 when rsp_result == 0.

Function
REQ-014 Op codes SHALL be: AND 0000, OR 0001, ADD 0010 (mod 2^DATA_W), SUB 0110 (A-B, mod 2^DATA_W), PASS-B 0111, NOR 1100; any other code yields result 0, zero 1.
REQ-015 Handshake: a transfer on either side occurs only when valid and ready are both 1 in the same cycle.
REQ-016 States SHALL be EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 Accept is allowed when state is EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill).
REQ-018 At most one reqN_ready SHALL be 1 per cycle; reqN_ready is 0 whenever accept is disallowed or reqN_valid is 0.
REQ-019 A request accepted in cycle n SHALL appear on rsp_* with rsp_valid=1 in cycle n+1 (latency 1).
REQ-020 Transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on accept with rsp_ready, or on no rsp_ready.
REQ-021 While FULL and rsp_ready=0, rsp_id/rsp_result/rsp_zero SHALL hold stable.
REQ-022 Only one valid requester: it is granted regardless of priority state.
REQ-023 Both valid: grant per REQ-030/031; the loser's ready stays 0 and its inputs need not be held by the arbiter.
REQ-024 The grant decision SHALL be combinational from current valids and the priority register; reqN_ready SHALL NOT depend on reqN_a/b/op.

Reset
REQ-025 On rst_n=0, asynchronously: state EMPTY, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, priority register points to requester 0.
REQ-026 Reset mid-operation SHALL discard any held response; no response is emitted for it after release.
REQ-027 reqN_ready SHALL be 0 while rst_n=0.

Configuration
REQ-028 Macro ALU_ARBITER_ROUND_ROBIN_EN selects the arbitration policy.
REQ-029 Without the macro: fixed priority, requester 0 always wins a tie; no priority register is implemented.
REQ-030 With the macro: a 1-bit last-grant register; on a tie the requester not granted last wins.
REQ-031 With the macro: the register updates only on an accepted transfer, to the granted index.

Structure
REQ-032 A shared package alu_pkg SHALL hold the six op-code constants, OP_W and DATA_W defaults.
REQ-033 The combinational operation SHALL live in sub-module alu_core (A, B, op -> result, zero); alu_arbiter instantiates one and registers its outputs.

Verification
REQ-034 Single req0: a=5, b=3, op=0010 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
REQ-035 req1 SUB a=7, b=7 -> rsp_result=0, rsp_zero=1; a=0, b=1 -> rsp_result=all ones, zero 0.
REQ-036 Both valid for 4 cycles, rsp_ready=1: with macro, grants 0,1,0,1; without macro, grants 0,0,0,0.
REQ-037 rsp_ready=0 for 3 cycles while FULL -> both readies 0, rsp_* unchanged; rsp_ready=1 with pending req -> drain and refill same cycle, no bubble.
REQ-038 Op 1111 with a=9, b=9 -> rsp_result=0, rsp_zero=1; NOR a=0, b=0 -> all ones, zero 0.
REQ-039 Assert rst_n=0 while FULL -> rsp_valid drops immediately; after release no stale response appears, round-robin restarts at requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, default widths and response-register state type
//
// Purpose : common definitions for alu_core and alu_arbiter.
// Contents: ALU_DATA_W / ALU_OP_W default widths, the six op-code constants,
//           and the EMPTY/FULL state enum of the response register.
package alu_pkg;

   localparam int ALU_DATA_W = 64;
   localparam int ALU_OP_W   = 4;

   localparam logic [ALU_OP_W-1:0] OP_AND  = 4'b0000;
   localparam logic [ALU_OP_W-1:0] OP_OR   = 4'b0001;
   localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'b0010;
   localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'b0110;
   localparam logic [ALU_OP_W-1:0] OP_PASSB = 4'b0111;
   localparam logic [ALU_OP_W-1:0] OP_NOR  = 4'b1100;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath
//
// Purpose : computes result and zero flag from operands and control code.
// Ports   : a_i, b_i   - DATA_W operands
//           op_i       - OP_W control code (AND, OR, ADD, SUB, PASS-B, NOR)
//           result_o   - DATA_W result, modulo 2^DATA_W for ADD/SUB
//           zero_o     - 1 when result_o == 0
//           Unknown op codes give result 0 (so zero_o = 1).
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [OP_W-1:0]   op_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_W'(OP_AND):   result_o = a_i & b_i;
         OP_W'(OP_OR):    result_o = a_i | b_i;
         OP_W'(OP_ADD):   result_o = a_i + b_i;
         OP_W'(OP_SUB):   result_o = a_i - b_i;
         OP_W'(OP_PASSB): result_o = b_i;
         OP_W'(OP_NOR):   result_o = ~(a_i | b_i);
         default:         result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared ALU with a registered response
//
// Purpose : grants one of two requesters per cycle, runs its operation through
//           alu_core and holds the result in a one-entry response register.
// Config  : ALU_ARBITER_ROUND_ROBIN_EN - defined: round-robin on ties using a
//           1-bit priority register; undefined: fixed priority, requester 0 wins.
// Ports   : clk, rst_n (async, active-low)
//           reqN_valid/reqN_ready, reqN_a/reqN_b/reqN_op (N = 0,1) - request side
//           rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_zero      - response side
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero
);

   rsp_state_e        state_q, state_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;

   logic              accept_ok;
   logic              prefer1;
   logic              gnt0, gnt1, accept;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic [OP_W-1:0]   alu_op;
   logic              alu_zero;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
   // Index of the requester that wins the next tie; 0 after reset.
   logic prio_q, prio_d;

   assign prefer1 = prio_q;

   always_comb begin
      prio_d = prio_q;
      // Winner of this transfer yields the next tie to the other requester.
      if (accept) begin
         prio_d = gnt0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
`else
   assign prefer1 = 1'b0;
`endif

   // rst_n gates accept so no ready is shown while reset is held.
   assign accept_ok = rst_n & ((state_q == ST_EMPTY) | rsp_ready);
   assign gnt0      = accept_ok & req0_valid & (~req1_valid | ~prefer1);
   assign gnt1      = accept_ok & req1_valid & (~req0_valid |  prefer1);
   assign accept    = gnt0 | gnt1;

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign alu_a  = gnt1 ? req1_a  : req0_a;
   assign alu_b  = gnt1 ? req1_b  : req0_b;
   assign alu_op = gnt1 ? req1_op : req0_op;

   alu_core #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu_core (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .op_i     (alu_op),
      .result_o (alu_result),
      .zero_o   (alu_zero)
   );

   always_comb begin
      state_d      = state_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;

      if (accept) begin
         rsp_id_d     = gnt1;
         rsp_result_d = alu_result;
         rsp_zero_d   = alu_zero;
      end

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (rsp_ready && !accept) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign rsp_valid  = (state_q == ST_FULL);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

endmodule
